// File: rtl/memport_arbiter.sv
`timescale 1ns/1ps
// memport_arbiter
//
// Arbiter and sequencer for the single shared memory port of the 5-stage
// pipeline. Instruction fetches (IF) and load/store accesses (MEM) are
// serialised onto one request/grant/response bus. MEM always wins over IF.
// A redirect (flush) discards an in-flight fetch: its bus handshake still
// completes, but no if_valid is produced for it.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   if_req, if_addr          fetch request (held until if_valid or flush)
//   if_rdata, if_valid       fetched instruction + one-cycle completion pulse
//   mem_req, mem_we,         data access request (held until mem_done),
//   mem_addr, mem_wdata,     store/load select, address, store data and
//   mem_wstrb                byte enables
//   mem_rdata, mem_done      load data + one-cycle completion pulse
//   flush                    branch/jump redirect, cancels the current fetch
//   stall_f, stall_m         hold PC and IF/ID / hold the whole pipeline
//   bus_req, bus_we,         bus request with registered payload, stable
//   bus_addr, bus_wdata,     from request until grant
//   bus_wstrb
//   bus_gnt                  request accepted this cycle
//   bus_rvalid, bus_rdata    response (read data or write ack)
module memport_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    // instruction fetch side
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic [DW-1:0]   if_rdata,
    output logic            if_valid,
    // data access side
    input  logic            mem_req,
    input  logic            mem_we,
    input  logic [AW-1:0]   mem_addr,
    input  logic [DW-1:0]   mem_wdata,
    input  logic [DW/8-1:0] mem_wstrb,
    output logic [DW-1:0]   mem_rdata,
    output logic            mem_done,
    // pipeline control
    input  logic            flush,
    output logic            stall_f,
    output logic            stall_m,
    // shared memory bus
    output logic            bus_req,
    output logic            bus_we,
    output logic [AW-1:0]   bus_addr,
    output logic [DW-1:0]   bus_wdata,
    output logic [DW/8-1:0] bus_wstrb,
    input  logic            bus_gnt,
    input  logic            bus_rvalid,
    input  logic [DW-1:0]   bus_rdata
);

    localparam int NB = DW / 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IF_REQ = 3'd1,
        IF_RSP = 3'd2,
        DM_REQ = 3'd3,
        DM_RSP = 3'd4
    } state_t;

    state_t          state_reg, state_next;
    logic            discard_reg, discard_next;

    logic            bus_we_reg, bus_we_next;
    logic [AW-1:0]   bus_addr_reg, bus_addr_next;
    logic [DW-1:0]   bus_wdata_reg, bus_wdata_next;
    logic [NB-1:0]   bus_wstrb_reg, bus_wstrb_next;

    // Payload load strobes; only asserted in IDLE, so the payload is frozen
    // for the whole REQ/RSP span of a transaction.
    logic            load_dm;
    logic            load_if;

    logic            rsp_if;
    logic            rsp_dm;

    // ------------------------------------------------------------------
    // State and payload registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            discard_reg   <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_addr_reg  <= '0;
            bus_wdata_reg <= '0;
            bus_wstrb_reg <= '0;
        end else begin
            state_reg     <= state_next;
            discard_reg   <= discard_next;
            bus_we_reg    <= bus_we_next;
            bus_addr_reg  <= bus_addr_next;
            bus_wdata_reg <= bus_wdata_next;
            bus_wstrb_reg <= bus_wstrb_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        discard_next = discard_reg;
        load_dm      = 1'b0;
        load_if      = 1'b0;

        case (state_reg)
            IDLE: begin
                // A response that shows up here (e.g. left over from an
                // access abandoned by reset) is deliberately ignored.
                discard_next = 1'b0;
                if (mem_req) begin
                    load_dm    = 1'b1;
                    state_next = DM_REQ;
                end else if (if_req && !flush) begin
                    load_if    = 1'b1;
                    state_next = IF_REQ;
                end
            end

            IF_REQ: begin
                if (flush) begin
                    discard_next = 1'b1;
                end
                if (bus_gnt) begin
                    state_next = IF_RSP;
                end
            end

            IF_RSP: begin
                if (flush) begin
                    discard_next = 1'b1;
                end
                if (bus_rvalid) begin
                    // Returning to IDLE always starts the next fetch clean.
                    discard_next = 1'b0;
                    state_next   = IDLE;
                end
            end

            DM_REQ: begin
                if (bus_gnt) begin
                    state_next = DM_RSP;
                end
            end

            DM_RSP: begin
                if (bus_rvalid) begin
                    discard_next = 1'b0;
                    state_next   = IDLE;
                end
            end

            default: begin
                discard_next = 1'b0;
                state_next   = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Payload capture. Fetches go out as reads with all strobes off and
    // zero write data so nothing stale from a previous store leaks out.
    // ------------------------------------------------------------------
    always_comb begin
        bus_we_next   = bus_we_reg;
        bus_addr_next = bus_addr_reg;
        if (load_dm) begin
            bus_we_next   = mem_we;
            bus_addr_next = mem_addr;
        end else if (load_if) begin
            bus_we_next   = 1'b0;
            bus_addr_next = if_addr;
        end
    end

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            always_comb begin
                bus_wdata_next[gi*8 +: 8] = bus_wdata_reg[gi*8 +: 8];
                bus_wstrb_next[gi]        = bus_wstrb_reg[gi];
                if (load_dm) begin
                    bus_wdata_next[gi*8 +: 8] = mem_wdata[gi*8 +: 8];
                    bus_wstrb_next[gi]        = mem_wstrb[gi];
                end else if (load_if) begin
                    bus_wdata_next[gi*8 +: 8] = 8'h00;
                    bus_wstrb_next[gi]        = 1'b0;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus_req   = (state_reg == IF_REQ) || (state_reg == DM_REQ);
    assign bus_we    = bus_we_reg;
    assign bus_addr  = bus_addr_reg;
    assign bus_wdata = bus_wdata_reg;
    assign bus_wstrb = bus_wstrb_reg;

    assign rsp_if = (state_reg == IF_RSP) && bus_rvalid;
    assign rsp_dm = (state_reg == DM_RSP) && bus_rvalid;

    // A flush arriving together with the response also kills the fetch,
    // since the instruction belongs to the path being abandoned.
    assign if_valid  = rsp_if && !discard_reg && !flush;
    assign if_rdata  = if_valid ? bus_rdata : '0;

    assign mem_done  = rsp_dm;
    assign mem_rdata = rsp_dm ? bus_rdata : '0;

    // Stalls are combinational so the pipeline advances on the very edge
    // that ends the completion-pulse cycle. Both are held low during reset.
    assign stall_m = !rst && mem_req && !mem_done;
    assign stall_f = !rst && (stall_m || (if_req && !if_valid && !flush));

endmodule

// File: doc/memport_arbiter.md
# memport_arbiter

Arbiter and sequencer for the single shared memory port of the 5-stage pipeline. It accepts instruction-fetch reads from IF and load/store accesses from MEM, serialises them onto one request/grant/response bus, and generates the stall signals that the hazard logic ORs into the pipeline-register enables. MEM always has priority over IF. A redirect (`flush`) discards an in-flight fetch.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width; `DW/8` byte strobes

- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `if_req`  in  1  fetch request, held until `if_valid` or `flush`
- `if_addr`  in  AW  fetch address
- `if_rdata`  out  DW  fetched instruction, valid with `if_valid`
- `if_valid`  out  1  one-cycle fetch completion pulse
- `mem_req`  in  1  data access request, held until `mem_done`
- `mem_we`  in  1  1 = store, 0 = load
- `mem_addr`  in  AW  data address
- `mem_wdata`  in  DW  store data
- `mem_wstrb`  in  DW/8  store byte enables
- `mem_rdata`  out  DW  load data, valid with `mem_done`
- `mem_done`  out  1  one-cycle data completion pulse
- `flush`  in  1  branch/jump redirect; cancels the current fetch
- `stall_f`  out  1  hold PC and IF/ID
- `stall_m`  out  1  hold the whole pipeline
- `bus_req`  out  1  bus request; held with stable payload until `bus_gnt`
- `bus_we`, `bus_addr`, `bus_wdata`, `bus_wstrb`  out  1/AW/DW/DW/8  registered payload
- `bus_gnt`  in  1  request accepted this cycle
- `bus_rvalid`  in  1  response (read data or write ack), at most one outstanding
- `bus_rdata`  in  DW  read data

## Operation
- FSM states: IDLE, IF_REQ, IF_RSP, DM_REQ, DM_RSP.
- IDLE:
  - If `mem_req`, go to DM_REQ and capture `mem_we/addr/wdata/wstrb` into the bus payload registers.
  - Otherwise, if `if_req && !flush`, go to IF_REQ and capture `if_addr` with `we=0` and `wstrb=0`.
- X_REQ: `bus_req=1`. On `bus_gnt`, go to X_RSP. The payload must not change while in X_REQ.
- X_RSP: `bus_req=0`. On `bus_rvalid`, return to IDLE.
  - DM_RSP: `mem_done=1` and `mem_rdata=bus_rdata`, both combinational in that cycle.
  - IF_RSP: `if_valid=1` and `if_rdata=bus_rdata`, unless a discard is pending.
- Discard flag:
  - Set by `flush` in IF_REQ or IF_RSP.
  - A discarded fetch still completes its bus handshake, but `if_valid` stays 0.
  - `flush` in the same cycle as `bus_rvalid` also suppresses `if_valid`.
  - Cleared on entry to IDLE.
- `bus_rvalid` in IDLE, IF_REQ or DM_REQ is ignored.
- Stall outputs:
  - `stall_m = mem_req && !mem_done`
  - `stall_f = stall_m || (if_req && !if_valid && !flush)`

## Timing
- Reset (async assert, sync-safe deassert):
  - State goes to IDLE; discard flag clears.
  - `bus_req=0`; `bus_we=0`, `bus_addr=0`, `bus_wdata=0`, `bus_wstrb=0`.
  - `if_valid=0`, `mem_done=0`; `stall_f` and `stall_m` are forced to 0 while `rst` is high.
  - Reset mid-transaction abandons it. Any later `bus_rvalid` arrives in IDLE and is ignored.
- Minimum latency, with `bus_gnt` in the first request cycle and `bus_rvalid` in the following cycle:
  - Request seen in IDLE at cycle 0.
  - `bus_req` asserted at cycle 1.
  - Completion pulse at cycle 2.
- At most one bus transaction is outstanding; no new request starts in the cycle a response arrives.
- Simultaneous `if_req` and `mem_req` in IDLE: MEM is served first, then IF starts the cycle after the return to IDLE if still requested.
- Requesters must drop or advance their request in the cycle after the completion pulse. The pipeline advances on that pulse edge.

## Test plan
- Fetch, zero wait: `if_req=1`, `if_addr=0x100`, `bus_gnt` immediate, `bus_rvalid` next cycle with `0x00500093` -> `bus_req` high exactly 1 cycle with addr `0x100`; `if_valid`=1 at cycle 2 with that data; `stall_f` high cycles 0-1.
- Store with wait states: `mem_req=1`, `mem_we=1`, addr `0x2000`, wdata `0xDEADBEEF`, wstrb `0xF`, `bus_gnt` after 3 cycles, ack 2 cycles later -> payload stable throughout; `mem_done` pulses once; `stall_m` and `stall_f` high until then.
- Collision: `if_req` and `mem_req` rise together -> DM load served first; IF_REQ begins the cycle after return to IDLE; `if_valid` never precedes `mem_done`.
- Flush in IF_RSP: `flush` pulses while waiting, response `0x12345678` arrives -> `if_valid` stays 0; new fetch of the redirected address starts from IDLE.
- Reset mid DM_RSP: assert `rst` asynchronously -> outputs 0 immediately; stale `bus_rvalid` after release produces no `mem_done`.
